// File: rtl/rom_stream_pkg.sv
// Shared types and defaults for the ROM stream reader.
package rom_stream_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/rom_stream_buf.sv
// Small synchronous FIFO holding captured ROM bytes ahead of the stream port.
module rom_stream_buf
    import rom_stream_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     pop,
    output logic [DATA_W-1:0]        data_out,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_q;
    logic [PW-1:0]     rd_q;
    logic [PW:0]       cnt_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                wr_q <= wr_q + PW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign data_out = mem_q[rd_q];
    assign count    = cnt_q;

endmodule

// File: rtl/rom_stream_reader.sv
// Walks a ROM address window and streams the bytes out with valid/ready/last.
// Optional running XOR of streamed bytes: define ROM_STREAM_CHECKSUM_EN.
module rom_stream_reader
    import rom_stream_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
`ifdef ROM_STREAM_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam int          CW      = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(BUF_DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   issue_cnt_q, issue_cnt_d;
    logic [ADDR_W:0]   out_cnt_q, out_cnt_d;
    logic              iss_q, iss_d;
    logic              done_q, done_d;

    logic [CW-1:0]     buf_cnt;
    logic [CW:0]       resv;
    logic              pop;
    logic              issue_ok;

    rom_stream_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (BUF_DEPTH)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .push     (iss_q),
        .data_in  (rom_data),
        .pop      (pop),
        .data_out (out_data),
        .count    (buf_cnt)
    );

    assign out_valid = (buf_cnt != '0);
    assign pop       = out_valid && out_ready;
    assign out_last  = out_valid && (out_cnt_q == CNT_ONE);

    // Slots held after this edge; a same-cycle pop frees one for sustained rate.
    assign resv = {1'b0, buf_cnt}
                + {{CW{1'b0}}, iss_q}
                - {{CW{1'b0}}, pop};

    assign issue_ok = (state_q == FETCH)
                   && (issue_cnt_q != '0)
                   && (resv < DEPTH_C);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        issue_cnt_d = issue_cnt_q;
        out_cnt_d   = out_cnt_q;
        iss_d       = 1'b0;
        done_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        state_d     = FETCH;
                        addr_d      = base_addr;
                        issue_cnt_d = length;
                        out_cnt_d   = length;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (issue_ok) begin
                    iss_d       = 1'b1;
                    issue_cnt_d = issue_cnt_q - CNT_ONE;
                    if (issue_cnt_q == CNT_ONE) begin
                        state_d = DRAIN;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            DRAIN: begin
                state_d = DRAIN;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (pop) begin
            out_cnt_d = out_cnt_q - CNT_ONE;
            if (out_cnt_q == CNT_ONE) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            issue_cnt_q <= '0;
            out_cnt_q   <= '0;
            iss_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            issue_cnt_q <= issue_cnt_d;
            out_cnt_q   <= out_cnt_d;
            iss_q       <= iss_d;
            done_q      <= done_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign rom_addr = addr_q;

`ifdef ROM_STREAM_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if ((state_q == IDLE) && start) begin
            csum_d = '0;
        end else if (pop) begin
            csum_d = csum_q ^ out_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`endif

endmodule
